// File: rtl/display_scheduler.sv
// Chooses which source the display shows (rotation, disabled-source skip and an urgent hold of
// source 2) and converts the chosen value to four registered BCD digits using double-dabble.
module display_scheduler #(
   parameter int unsigned ROTATE_TICKS  = 100000000,
   parameter int unsigned HOLD_TICKS    = 200000000,
   parameter int unsigned REFRESH_TICKS = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  src_en,
   input  logic [31:0] src0_val,
   input  logic [31:0] src1_val,
   input  logic [31:0] src2_val,
   input  logic        urgent,
   output logic [1:0]  sel,
   output logic [3:0]  thousand,
   output logic [3:0]  hundred,
   output logic [3:0]  ten,
   output logic [3:0]  one,
   output logic        bcd_valid,
   output logic        busy
);

   localparam int ROT_W  = (ROTATE_TICKS > 1)  ? $clog2(ROTATE_TICKS)  : 1;
   localparam int HOLD_W = (HOLD_TICKS > 1)    ? $clog2(HOLD_TICKS)    : 1;
   localparam int REF_W  = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;

   localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROTATE_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_TICKS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [2:0] en);
      logic [1:0] a;
      logic [1:0] b;
      a = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
      b = (a == 2'd2) ? 2'd0 : a + 2'd1;
      if (en[a])      next_en = a;
      else if (en[b]) next_en = b;
      else            next_en = cur;
   endfunction

   function automatic logic [1:0] first_en(input logic [2:0] en);
      if (en[1] && !en[0])                 first_en = 2'd1;
      else if (en[2] && !en[0] && !en[1])  first_en = 2'd2;
      else                                 first_en = 2'd0;
   endfunction

   // One double-dabble step: correct every BCD nibble that would overflow, then shift left.
   function automatic logic [29:0] dabble(input logic [29:0] s);
      logic [29:0] t;
      t = s;
      for (int k = 0; k < 4; k++) begin
         if (t[14+4*k +: 4] >= 4'd5) t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
      end
      dabble = {t[28:0], 1'b0};
   endfunction

   logic [1:0]        sel_q, sel_d;
   logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              holding_q, holding_d;
   logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
   logic              first_q, first_d;
   logic              start_q, start_d;
   logic              ref_tc;
   state_t            state_q, state_d;
   logic              pend_q, pend_d;
   logic [29:0]       sr_q, sr_d;
   logic [3:0]        iter_q, iter_d;
   logic [15:0]       digits_q, digits_d;
   logic              valid_q, valid_d;
   logic [31:0]       raw_val;
   logic [13:0]       load_val;

   always_comb begin
      sel_d      = sel_q;
      rot_cnt_d  = rot_cnt_q;
      hold_cnt_d = hold_cnt_q;
      holding_d  = holding_q;
      if (urgent) begin
         sel_d      = 2'd2;
         holding_d  = 1'b1;
         hold_cnt_d = HOLD_LAST;
      end else if (holding_q) begin
         if (hold_cnt_q == '0) begin
            holding_d = 1'b0;
            sel_d     = first_en(src_en);
            rot_cnt_d = '0;
         end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
         end
      end else if (src_en != 3'b000 && !src_en[sel_q]) begin
         sel_d     = next_en(sel_q, src_en);
         rot_cnt_d = '0;
      end else if (rot_cnt_q == ROT_LAST) begin
         sel_d     = next_en(sel_q, src_en);
         rot_cnt_d = '0;
      end else begin
         rot_cnt_d = rot_cnt_q + 1'b1;
      end

      ref_tc    = (ref_cnt_q == REF_LAST);
      ref_cnt_d = ref_tc ? '0 : ref_cnt_q + 1'b1;
      start_d   = first_q | (sel_d != sel_q) | ref_tc;
      first_d   = 1'b0;
   end

   // During an urgent hold source 2 is shown even when it is not enabled.
   always_comb begin
      raw_val = 32'd0;
      if (holding_q) begin
         raw_val = src2_val;
      end else if (src_en != 3'b000) begin
         case (sel_q)
            2'd0:    raw_val = src0_val;
            2'd1:    raw_val = src1_val;
            default: raw_val = src2_val;
         endcase
      end
      load_val = (raw_val > 32'd9999) ? 14'd9999 : raw_val[13:0];
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      sr_d     = sr_q;
      iter_d   = iter_q;
      digits_d = digits_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_q) state_d = LOAD;
         end
         LOAD: begin
            sr_d    = {16'd0, load_val};
            iter_d  = 4'd0;
            state_d = SHIFT;
            if (start_q) pend_d = 1'b1;
         end
         SHIFT: begin
            sr_d   = dabble(sr_q);
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'd13) state_d = DONE;
            if (start_q) pend_d = 1'b1;
         end
         default: begin
            digits_d = sr_q[29:14];
            valid_d  = 1'b1;
            if (pend_q || start_q) begin
               state_d = LOAD;
               pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q      <= 2'd0;
         rot_cnt_q  <= '0;
         hold_cnt_q <= '0;
         holding_q  <= 1'b0;
         ref_cnt_q  <= '0;
         first_q    <= 1'b1;
         start_q    <= 1'b0;
         state_q    <= IDLE;
         pend_q     <= 1'b0;
         sr_q       <= '0;
         iter_q     <= 4'd0;
         digits_q   <= 16'd0;
         valid_q    <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         rot_cnt_q  <= rot_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         holding_q  <= holding_d;
         ref_cnt_q  <= ref_cnt_d;
         first_q    <= first_d;
         start_q    <= start_d;
         state_q    <= state_d;
         pend_q     <= pend_d;
         sr_q       <= sr_d;
         iter_q     <= iter_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
      end
   end

   assign sel                          = sel_q;
   assign {thousand, hundred, ten, one} = digits_q;
   assign bcd_valid                    = valid_q;
   assign busy                         = (state_q != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: a cycle-indexed behavioural model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_display_scheduler;

   localparam int ROT  = 8;
   localparam int HOLD = 20;
   localparam int REFR = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  src_en = 3'b000;
   logic [31:0] src0_val = 32'd0;
   logic [31:0] src1_val = 32'd0;
   logic [31:0] src2_val = 32'd0;
   logic        urgent = 1'b0;
   logic [1:0]  sel;
   logic [3:0]  thousand, hundred, ten, one;
   logic        bcd_valid;
   logic        busy;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 1'b0;
   int cyc = 0;

   display_scheduler #(
      .ROTATE_TICKS (ROT),
      .HOLD_TICKS   (HOLD),
      .REFRESH_TICKS(REFR)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .src_en   (src_en),
      .src0_val (src0_val),
      .src1_val (src1_val),
      .src2_val (src2_val),
      .urgent   (urgent),
      .sel      (sel),
      .thousand (thousand),
      .hundred  (hundred),
      .ten      (ten),
      .one      (one),
      .bcd_valid(bcd_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] en, input logic [31:0] v0,
                                input logic [31:0] v1, input logic [31:0] v2);
      src_en   = en;
      src0_val = v0;
      src1_val = v1;
      src2_val = v2;
      urgent   = 1'b0;
   endtask

   function automatic logic [1:0] next_enabled(input int cur, input logic [2:0] en);
      for (int k = 1; k <= 3; k++) begin
         if (en[(cur + k) % 3]) return 2'((cur + k) % 3);
      end
      return 2'(cur);
   endfunction

   function automatic logic [1:0] lowest_enabled(input logic [2:0] en);
      for (int k = 0; k < 3; k++) begin
         if (en[k]) return 2'(k);
      end
      return 2'd0;
   endfunction

   function automatic int shown_value(input bit hold, input logic [1:0] s, input logic [2:0] en,
                                      input logic [31:0] v0, input logic [31:0] v1,
                                      input logic [31:0] v2);
      logic [31:0] r;
      if (hold)             r = v2;
      else if (en == 3'b0)  r = 32'd0;
      else if (s == 2'd0)   r = v0;
      else if (s == 2'd1)   r = v1;
      else                  r = v2;
      return (r > 32'd9999) ? 9999 : int'(r);
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(9990, 10010));
         default: return 32'($urandom_range(0, 9999));
      endcase
   endfunction

   // Edge counter since the last reset release; cycle k is the interval after the k-th edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Reference model: selection rules as counters, conversion as a timeline of cycle indices
   // (request cycle c -> LOAD at c+1 -> DONE at c+16 -> digits and valid at c+17).
   logic [1:0] m_sel = 2'd0;
   int  m_rot = 0, m_hold = 0, m_ref = 0, m_cyc = 0, conv_load = -1, m_val = 0;
   bit  m_holding = 1'b0, m_first = 1'b1, m_start = 1'b0, m_pend = 1'b0;
   logic [1:0] e_sel = 2'd0;
   bit  e_busy = 1'b0, e_valid = 1'b0;
   int  e_dig = 0;

   always @(posedge clk or negedge reset) begin : model
      int c;
      bit busy_c;
      bit ref_tc;
      logic [1:0] old_sel;
      if (!reset) begin
         m_sel = 2'd0; m_rot = 0; m_hold = 0; m_ref = 0; m_cyc = 0; conv_load = -1;
         m_holding = 1'b0; m_first = 1'b1; m_start = 1'b0; m_pend = 1'b0;
         e_sel = 2'd0; e_busy = 1'b0; e_valid = 1'b0; e_dig = 0;
      end else begin
         c = m_cyc;
         busy_c = (conv_load >= 0) && (c >= conv_load) && (c <= conv_load + 15);
         e_valid = 1'b0;
         if (conv_load >= 0 && c == conv_load)
            m_val = shown_value(m_holding, m_sel, src_en, src0_val, src1_val, src2_val);
         if (busy_c && c == conv_load + 15) begin
            e_valid = 1'b1;
            e_dig   = m_val;
         end
         if (!busy_c) begin
            if (m_start) conv_load = c + 1;
         end else if (c == conv_load + 15) begin
            if (m_pend || m_start) begin
               conv_load = c + 1;
               m_pend    = 1'b0;
            end else begin
               conv_load = -1;
            end
         end else if (m_start) begin
            m_pend = 1'b1;
         end

         old_sel = m_sel;
         if (urgent) begin
            m_sel = 2'd2; m_holding = 1'b1; m_hold = HOLD - 1;
         end else if (m_holding) begin
            if (m_hold == 0) begin
               m_holding = 1'b0; m_sel = lowest_enabled(src_en); m_rot = 0;
            end else begin
               m_hold--;
            end
         end else if (src_en != 3'b000 && !src_en[m_sel]) begin
            m_sel = next_enabled(int'(m_sel), src_en); m_rot = 0;
         end else if (m_rot == ROT - 1) begin
            m_sel = next_enabled(int'(m_sel), src_en); m_rot = 0;
         end else begin
            m_rot++;
         end

         ref_tc  = (m_ref == REFR - 1);
         m_ref   = ref_tc ? 0 : m_ref + 1;
         m_start = m_first || (m_sel != old_sel) || ref_tc;
         m_first = 1'b0;
         m_cyc   = c + 1;
         e_sel   = m_sel;
         e_busy  = (conv_load >= 0) && (m_cyc >= conv_load) && (m_cyc <= conv_load + 15);
      end
   end

   // Every cycle: all outputs against the model, plus the digit range.
   always @(negedge clk) begin
      if (cmp_on) begin
         checkOutput("sel", 32'(sel), 32'(e_sel));
         checkOutput("busy", 32'(busy), 32'(e_busy));
         checkOutput("bcd_valid", 32'(bcd_valid), 32'(e_valid));
         checkOutput("digits", 32'({thousand, hundred, ten, one}), 32'(to_bcd(e_dig)));
         checkOutput("digit_range",
                     32'(thousand <= 4'd9 && hundred <= 4'd9 && ten <= 4'd9 && one <= 4'd9), 1);
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic wait_cycle(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #2;
      end
   endtask

   int c_cyc[6] = '{7, 8, 15, 16, 23, 24};
   int c_sel[6] = '{0, 2, 2, 0, 0, 2};
   int cnt, first_c, second_c;
   logic [15:0] d1, d2;

   initial begin
      #400000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 reset = 1'b0;
      #1 cmp_on = 1'b1;

      // Single source, 1234: first result 17 cycles after the post-reset request.
      applyStimulus(3'b001, 32'd1234, 32'd5678, 32'd42);
      do_reset();
      wait_cycle(17);
      checkOutput("a_valid_early", 32'(bcd_valid), 0);
      wait_cycle(18);
      checkOutput("a_valid", 32'(bcd_valid), 1);
      checkOutput("a_digits", 32'({thousand, hundred, ten, one}), 32'h1234);
      checkOutput("a_sel", 32'(sel), 0);

      // Saturation, then a refresh conversion picks up 0.
      applyStimulus(3'b001, 32'hFFFF_FFFF, 32'd1, 32'd2);
      do_reset();
      wait_cycle(18);
      checkOutput("b_sat", 32'({thousand, hundred, ten, one}), 32'h9999);
      wait_cycle(20);
      src0_val = 32'd0;
      wait_cycle(66);
      checkOutput("b_hold_digits", 32'({thousand, hundred, ten, one}), 32'h9999);
      checkOutput("b_valid_early", 32'(bcd_valid), 0);
      wait_cycle(67);
      checkOutput("b_valid", 32'(bcd_valid), 1);
      checkOutput("b_zero", 32'({thousand, hundred, ten, one}), 32'h0000);

      // Reset in SHIFT iteration 7 of the refresh conversion.
      applyStimulus(3'b001, 32'd1234, 32'd0, 32'd0);
      do_reset();
      wait_cycle(59);
      checkOutput("f_busy_mid", 32'(busy), 1);
      #1 reset = 1'b0;
      #1;
      checkOutput("f_digits_rst", 32'({thousand, hundred, ten, one}), 0);
      checkOutput("f_busy_rst", 32'(busy), 0);
      checkOutput("f_valid_rst", 32'(bcd_valid), 0);
      @(negedge clk);
      #1 reset = 1'b1;
      wait_cycle(17);
      checkOutput("f_valid_early", 32'(bcd_valid), 0);
      wait_cycle(18);
      checkOutput("f_valid", 32'(bcd_valid), 1);
      checkOutput("f_digits", 32'({thousand, hundred, ten, one}), 32'h1234);

      // Selected source disabled mid-conversion: exactly one queued conversion of the new source.
      applyStimulus(3'b001, 32'd1234, 32'd5678, 32'd0);
      do_reset();
      wait_cycle(5);
      src_en = 3'b010;
      cnt = 0; first_c = 0; second_c = 0; d1 = 16'd0; d2 = 16'd0;
      for (int k = 6; k < 50; k++) begin
         wait_cycle(k);
         if (k == 6) checkOutput("d_sel_jump", 32'(sel), 1);
         if (bcd_valid) begin
            cnt++;
            if (cnt == 1) begin first_c = k;  d1 = {thousand, hundred, ten, one}; end
            if (cnt == 2) begin second_c = k; d2 = {thousand, hundred, ten, one}; end
         end
      end
      checkOutput("d_valid_count", 32'(cnt), 2);
      checkOutput("d_first_cycle", 32'(first_c), 18);
      checkOutput("d_first_digits", 32'(d1), 32'h1234);
      checkOutput("d_second_cycle", 32'(second_c), 34);
      checkOutput("d_second_digits", 32'(d2), 32'h5678);

      // Rotation over sources 0 and 2.
      applyStimulus(3'b101, 32'd111, 32'd0, 32'd222);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         wait_cycle(c_cyc[i]);
         checkOutput($sformatf("c_sel_%0d", c_cyc[i]), 32'(sel), 32'(c_sel[i]));
      end

      // Urgent hold with a retrigger 10 cycles in: 30 cycles on source 2.
      applyStimulus(3'b011, 32'd100, 32'd200, 32'd300);
      do_reset();
      wait_cycle(10);
      checkOutput("e_sel_pre", 32'(sel), 1);
      urgent = 1'b1;
      cnt = 0;
      for (int k = 11; k <= 40; k++) begin
         wait_cycle(k);
         if (k == 11 || k == 21) urgent = 1'b0;
         if (k == 20) urgent = 1'b1;
         if (sel == 2'd2) cnt++;
      end
      checkOutput("e_hold_cycles", 32'(cnt), 30);
      wait_cycle(41);
      checkOutput("e_sel_resume", 32'(sel), 0);
      wait_cycle(48);
      checkOutput("e_sel_48", 32'(sel), 0);
      wait_cycle(49);
      checkOutput("e_sel_49", 32'(sel), 1);

      // Randomized traffic against the model.
      applyStimulus(3'b111, rand_val(), rand_val(), rand_val());
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #2;
         urgent = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 39) == 0) src_en = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
               0:       src0_val = rand_val();
               1:       src1_val = rand_val();
               default: src2_val = rand_val();
            endcase
         end
         if ($urandom_range(0, 1499) == 0) begin
            reset = 1'b0;
            @(negedge clk);
            #1 reset = 1'b1;
         end
      end
      urgent = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
